// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Owner encoding, default memory depth, requester indices.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_DATA  = 2'd1,
    OWN_FETCH = 2'd2,
    OWN_DBG   = 2'd3
  } owner_e;

  localparam int DEPTH_DEF = 51;

  localparam int REQ_DATA  = 0;
  localparam int REQ_FETCH = 1;
  localparam int REQ_DBG   = 2;
  localparam int NREQ      = 3;

endpackage

// File: rtl/mem_arb_age.sv
// Debug-port aging counter: counts cycles the debug request waits.
// Ports: clk1, reset (async, active-high), g_req_i, g_gnt_i in;
// promote_o out. Used only when MEM_ARB_AGING_EN is defined.
import mem_arb_pkg::*;

module mem_arb_age #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk1,
  input  logic reset,
  input  logic g_req_i,
  input  logic g_gnt_i,
  output logic promote_o
);

  localparam logic [7:0] MAXW = 8'(MAX_WAIT);

  logic [7:0] age_q, age_d;

  always_comb begin
    age_d = age_q;
    if (g_gnt_i || !g_req_i)
      age_d = '0;
    else if (age_q != MAXW)
      age_d = age_q + 8'd1;
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset)
      age_q <= '0;
    else
      age_q <= age_d;
  end

  // A stale count is ignored once the request is withdrawn.
  assign promote_o = g_req_i && (age_q == MAXW);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data > fetch > debug, 1-cycle read return.
// Ports: clk1, reset; d_*/f_*/g_* requesters; mem_* array side;
// addr_err, busy. Define MEM_ARB_AGING_EN for debug anti-starvation.
import mem_arb_pkg::*;

module mem_port_arbiter #(
  parameter int AW       = 6,
  parameter int DW       = 32,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk1,
  input  logic          reset,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  input  logic          g_req,
  input  logic [AW-1:0] g_addr,
  output logic          g_gnt,
  output logic          g_rvalid,
  output logic [DW-1:0] g_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          addr_err,
  output logic          busy
);

  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_wait
    $error("MAX_WAIT must be 1..255");
  end

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  logic            promote;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;

  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_we;
  logic          in_range;
  logic          any_gnt;

  owner_e owner_q, owner_d;
  logic   err_q, err_d;
  logic [DW-1:0] rdata_ok;

`ifdef MEM_ARB_AGING_EN
  mem_arb_age #(
    .MAX_WAIT (MAX_WAIT)
  ) u_age (
    .clk1      (clk1),
    .reset     (reset),
    .g_req_i   (g_req),
    .g_gnt_i   (g_gnt),
    .promote_o (promote)
  );
`else
  assign promote = 1'b0;
`endif

  // No grants while reset is held, so every output sits at 0.
  assign req = {g_req, f_req, d_req} & {NREQ{~reset}};

  always_comb begin
    gnt = '0;
    if (promote && req[REQ_DBG])
      gnt[REQ_DBG] = 1'b1;
    else if (req[REQ_DATA])
      gnt[REQ_DATA] = 1'b1;
    else if (req[REQ_FETCH])
      gnt[REQ_FETCH] = 1'b1;
    else if (req[REQ_DBG])
      gnt[REQ_DBG] = 1'b1;
  end

  assign d_gnt = gnt[REQ_DATA];
  assign f_gnt = gnt[REQ_FETCH];
  assign g_gnt = gnt[REQ_DBG];
  assign any_gnt = |gnt;

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    owner_d   = OWN_NONE;
    unique case (1'b1)
      gnt[REQ_DATA]: begin
        sel_addr  = d_addr;
        sel_wdata = d_wdata;
        sel_we    = d_we;
        owner_d   = d_we ? OWN_NONE : OWN_DATA;
      end
      gnt[REQ_FETCH]: begin
        sel_addr = f_addr;
        owner_d  = OWN_FETCH;
      end
      gnt[REQ_DBG]: begin
        sel_addr = g_addr;
        owner_d  = OWN_DBG;
      end
      default: ;
    endcase
  end

  assign in_range = 32'(sel_addr) < DEPTH_U;
  assign err_d    = ~in_range;

  assign mem_en    = any_gnt & in_range;
  assign mem_we    = sel_we & in_range;
  assign mem_addr  = sel_addr;
  assign mem_wdata = sel_wdata;
  assign addr_err  = any_gnt & ~in_range;

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      owner_q <= OWN_NONE;
      err_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  // An out-of-range read never touched the array: return zero.
  assign rdata_ok = err_q ? '0 : mem_rdata;

  assign d_rvalid = (owner_q == OWN_DATA);
  assign f_rvalid = (owner_q == OWN_FETCH);
  assign g_rvalid = (owner_q == OWN_DBG);

  assign d_rdata = d_rvalid ? rdata_ok : '0;
  assign f_rdata = f_rvalid ? rdata_ok : '0;
  assign g_rdata = g_rvalid ? rdata_ok : '0;

  assign busy = (owner_q != OWN_NONE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a memory model
// and a transaction-level reference of grants and read returns.
module tb_mem_port_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int DEPTH = 51;
  localparam int MAX_WAIT = 8;
`ifdef MEM_ARB_AGING_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif

  logic clk1 = 1'b0;
  logic reset;
  logic d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic f_req;
  logic [AW-1:0] f_addr;
  logic f_gnt, f_rvalid;
  logic [DW-1:0] f_rdata;
  logic g_req;
  logic [AW-1:0] g_addr;
  logic g_gnt, g_rvalid;
  logic [DW-1:0] g_rdata;
  logic mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic addr_err, busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [64];
  logic [DW-1:0] ref_mem [64];

  int m_owner;
  int m_age;
  bit m_err;
  logic [DW-1:0] m_data;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk1(clk1), .reset(reset),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .g_req(g_req), .g_addr(g_addr), .g_gnt(g_gnt),
    .g_rvalid(g_rvalid), .g_rdata(g_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .addr_err(addr_err), .busy(busy)
  );

  always #5 clk1 = ~clk1;

  // Memory array; idle cycles return noise on the read bus.
  always @(posedge clk1) begin
    if (mem_en && mem_we)
      mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we)
      mem_rdata <= mem[mem_addr];
    else
      mem_rdata <= $urandom;
  end

  function automatic int winner();
    if (reset) return 0;
    if (AGING && g_req && m_age == MAX_WAIT) return 3;
    if (d_req) return 1;
    if (f_req) return 2;
    if (g_req) return 3;
    return 0;
  endfunction

  function automatic int waddr(int w);
    case (w)
      1: return int'(d_addr);
      2: return int'(f_addr);
      3: return int'(g_addr);
      default: return 0;
    endcase
  endfunction

  // Reference: which requester owns the return, and its data.
  always @(posedge clk1 or posedge reset) begin
    int w, a;
    if (reset) begin
      m_owner = 0; m_err = 0; m_data = '0; m_age = 0;
    end else begin
      w = winner();
      a = waddr(w);
      m_owner = (w == 1 && d_we) ? 0 : w;
      m_err = (a >= DEPTH);
      m_data = (a < DEPTH) ? ref_mem[a] : '0;
      if (w == 1 && d_we && a < DEPTH) ref_mem[a] = d_wdata;
      if (w == 3 || !g_req) m_age = 0;
      else if (m_age < MAX_WAIT) m_age = m_age + 1;
    end
  end

  task automatic idle();
    d_req = 0; d_we = 0; f_req = 0; g_req = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    d_req = 1; d_addr = 5; d_we = 0;
    f_req = 1; f_addr = 3; g_req = 1; g_addr = 2;
    repeat (2) @(posedge clk1);
    #1;
    checks++;
    if ({d_gnt, f_gnt, g_gnt, mem_en, mem_we, addr_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl got=%b exp=000000",
        {d_gnt, f_gnt, g_gnt, mem_en, mem_we, addr_err});
    end
    checks++;
    if ({d_rvalid, f_rvalid, g_rvalid, busy} !== 4'b0) begin
      errors++;
      $display("FAIL reset_rv got=%b exp=0000",
        {d_rvalid, f_rvalid, g_rvalid, busy});
    end
    checks++;
    if ({d_rdata, f_rdata, g_rdata, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_data got=%h exp=0",
        {d_rdata, f_rdata, g_rdata, mem_addr, mem_wdata});
    end
    idle();
    reset = 0;
    @(posedge clk1); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_priority();
    d_req = 1; d_we = 0; d_addr = 30; f_req = 1; f_addr = 4;
    #4;
    checks++;
    if ({d_gnt, f_gnt, mem_en, mem_we} !== 4'b1010
        || mem_addr !== 6'd30) begin
      errors++;
      $display("FAIL prio_gnt got=%b addr=%0d exp=1010 addr=30",
        {d_gnt, f_gnt, mem_en, mem_we}, mem_addr);
    end
    @(posedge clk1); #1;
    d_req = 0;
    #4;
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'd10) begin
      errors++;
      $display("FAIL prio_rdata got=%b/%0d exp=1/10", d_rvalid, d_rdata);
    end
    checks++;
    if (f_gnt !== 1'b1 || mem_addr !== 6'd4) begin
      errors++;
      $display("FAIL prio_fetch got=%b/%0d exp=1/4", f_gnt, mem_addr);
    end
    @(posedge clk1); #1;
    f_req = 0;
    #4;
    checks++;
    if (f_rvalid !== 1'b1 || f_rdata !== 32'd104 || d_rdata !== '0) begin
      errors++;
      $display("FAIL prio_frd got=%b/%0d d=%0d exp=1/104 d=0",
        f_rvalid, f_rdata, d_rdata);
    end
    @(posedge clk1); #1;
  endtask

  task automatic test_write();
    d_req = 1; d_we = 1; d_addr = 33; d_wdata = 55;
    #4;
    checks++;
    if ({d_gnt, mem_en, mem_we} !== 3'b111 || mem_wdata !== 32'd55) begin
      errors++;
      $display("FAIL wr_cmd got=%b/%0d exp=111/55",
        {d_gnt, mem_en, mem_we}, mem_wdata);
    end
    @(posedge clk1); #1;
    idle();
    #4;
    checks++;
    if ({mem_we, d_rvalid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL wr_norv got=%b exp=000", {mem_we, d_rvalid, busy});
    end
    @(posedge clk1); #1;
    g_req = 1; g_addr = 33;
    #4;
    checks++;
    if (g_gnt !== 1'b1) begin
      errors++; $display("FAIL wr_ggnt got=%b exp=1", g_gnt);
    end
    @(posedge clk1); #1;
    g_req = 0;
    #4;
    checks++;
    if (g_rvalid !== 1'b1 || g_rdata !== 32'd55) begin
      errors++;
      $display("FAIL wr_readback got=%b/%0d exp=1/55", g_rvalid, g_rdata);
    end
    @(posedge clk1); #1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      f_req = (i < 5);
      f_addr = AW'(i);
      #4;
      if (i < 5) begin
        checks++;
        if (f_gnt !== 1'b1 || mem_addr !== AW'(i)) begin
          errors++;
          $display("FAIL b2b_gnt[%0d] got=%b/%0d exp=1/%0d",
            i, f_gnt, mem_addr, i);
        end
      end
      if (i > 0) begin
        checks++;
        if (f_rvalid !== 1'b1 || f_rdata !== DW'(100 + i - 1)) begin
          errors++;
          $display("FAIL b2b_rd[%0d] got=%b/%0d exp=1/%0d",
            i, f_rvalid, f_rdata, 100 + i - 1);
        end
      end
      @(posedge clk1); #1;
    end
    idle();
  endtask

  task automatic test_addr_err();
    g_req = 1; g_addr = 60;
    #4;
    checks++;
    if ({g_gnt, mem_en, addr_err} !== 3'b101) begin
      errors++;
      $display("FAIL oor_cmd got=%b exp=101", {g_gnt, mem_en, addr_err});
    end
    @(posedge clk1); #1;
    g_req = 0;
    #4;
    checks++;
    if (g_rvalid !== 1'b1 || g_rdata !== '0 || addr_err !== 1'b0) begin
      errors++;
      $display("FAIL oor_rd got=%b/%0d err=%b exp=1/0 err=0",
        g_rvalid, g_rdata, addr_err);
    end
    @(posedge clk1); #1;
  endtask

  task automatic test_aging();
    int got = 0;
    int exp_cyc = AGING ? MAX_WAIT + 1 : 0;
    for (int c = 1; c <= 20 && got == 0; c++) begin
      f_req = 1; f_addr = AW'(c % 8);
      g_req = 1; g_addr = 7;
      #4;
      if (g_gnt === 1'b1) got = c;
      @(posedge clk1); #1;
    end
    idle();
    checks++;
    if (got != exp_cyc) begin
      errors++;
      $display("FAIL aging_cycle got=%0d exp=%0d", got, exp_cyc);
    end
    @(posedge clk1); #1;
  endtask

  task automatic test_random(int n);
    int w, a;
    int w_prev = 0;
    logic [DW-1:0] erd;
    for (int i = 0; i < n; i++) begin
      if (w_prev == 1 || !d_req) begin
        d_req = 1'($urandom_range(0, 1));
        d_we = ($urandom_range(0, 3) == 0);
        d_addr = AW'($urandom_range(0, 63));
        d_wdata = $urandom;
      end else if ($urandom_range(0, 9) == 0) d_req = 0;
      if (w_prev == 2 || !f_req) begin
        f_req = 1'($urandom_range(0, 1));
        f_addr = AW'($urandom_range(0, 63));
      end else if ($urandom_range(0, 9) == 0) f_req = 0;
      if (w_prev == 3 || !g_req) begin
        g_req = 1'($urandom_range(0, 1));
        g_addr = AW'($urandom_range(0, 63));
      end
      #4;
      w = winner();
      a = waddr(w);
      checks++;
      if ({d_gnt, f_gnt, g_gnt} !== {w == 1, w == 2, w == 3}) begin
        errors++;
        $display("FAIL rand_gnt[%0d] got=%b exp=%b", i,
          {d_gnt, f_gnt, g_gnt}, {w == 1, w == 2, w == 3});
      end
      checks++;
      if ({mem_en, mem_we, addr_err} !==
          {w != 0 && a < DEPTH, w == 1 && d_we && a < DEPTH,
           w != 0 && a >= DEPTH}) begin
        errors++;
        $display("FAIL rand_cmd[%0d] got=%b w=%0d a=%0d", i,
          {mem_en, mem_we, addr_err}, w, a);
      end
      checks++;
      if (mem_addr !== AW'(a)) begin
        errors++;
        $display("FAIL rand_addr[%0d] got=%0d exp=%0d", i, mem_addr, a);
      end
      if (w == 1 && d_we && a < DEPTH) begin
        checks++;
        if (mem_wdata !== d_wdata) begin
          errors++;
          $display("FAIL rand_wdata[%0d] got=%h exp=%h", i,
            mem_wdata, d_wdata);
        end
      end
      checks++;
      if ({d_rvalid, f_rvalid, g_rvalid, busy} !==
          {m_owner == 1, m_owner == 2, m_owner == 3, m_owner != 0}) begin
        errors++;
        $display("FAIL rand_rv[%0d] got=%b owner=%0d", i,
          {d_rvalid, f_rvalid, g_rvalid, busy}, m_owner);
      end
      erd = m_err ? '0 : m_data;
      checks++;
      if (d_rdata !== (m_owner == 1 ? erd : '0)
          || f_rdata !== (m_owner == 2 ? erd : '0)
          || g_rdata !== (m_owner == 3 ? erd : '0)) begin
        errors++;
        $display("FAIL rand_rdata[%0d] got=%h/%h/%h exp=%h owner=%0d",
          i, d_rdata, f_rdata, g_rdata, erd, m_owner);
      end
      w_prev = w;
      @(posedge clk1); #1;
    end
    idle();
    @(posedge clk1); #1;
  endtask

  task automatic test_reset_mid();
    d_req = 1; d_we = 0; d_addr = 12;
    #4;
    checks++;
    if (d_gnt !== 1'b1) begin
      errors++; $display("FAIL rmid_gnt got=%b exp=1", d_gnt);
    end
    #4;
    reset = 1;
    d_req = 0;
    @(posedge clk1); #1;
    checks++;
    if (d_rvalid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_rv got=%b/%b exp=0/0", d_rvalid, busy);
    end
    @(posedge clk1); #1;
    reset = 0;
    #4;
    checks++;
    if ({d_gnt, f_gnt, g_gnt, d_rvalid, f_rvalid, g_rvalid,
         mem_en, mem_we, addr_err, busy} !== 10'b0
        || {d_rdata, f_rdata, g_rdata, mem_addr} !== '0) begin
      errors++;
      $display("FAIL rmid_after got=%b exp=0", {d_gnt, f_gnt, g_gnt,
        d_rvalid, f_rvalid, g_rvalid, mem_en, mem_we, addr_err, busy});
    end
    @(posedge clk1); #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = DW'(100 + i);
      ref_mem[i] = DW'(100 + i);
    end
    mem[30] = 32'd10;
    ref_mem[30] = 32'd10;
    d_wdata = '0;
    idle();
    test_reset();
    test_priority();
    test_write();
    test_back_to_back();
    test_addr_err();
    test_aging();
    test_random(400);
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
